// File: rtl/snd_dma_seq.sv
// snd_dma_seq: round-robin multi-channel sound DMA sequencer with per-channel frame address counters
// Optional feature: define SND_DMA_SHADOW_EN to latch each channel's end address per frame instead of using the live port.
module snd_dma_seq #(
  parameter int NCH = 2,
  parameter int AW = 21,
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              por,
  input  logic              slot,
  input  logic [NCH-1:0]    snd_on,
  input  logic [NCH-1:0]    rep,
  input  logic [NCH*AW-1:0] start_addr,
  input  logic [NCH*AW-1:0] end_addr,
  input  logic [NCH-1:0]    sreq,
  input  logic [NCH-1:0]    int_ack,
  output logic              dma_load,
  output logic [CW-1:0]     dma_ch,
  output logic [AW-1:0]     dma_addr,
  output logic [NCH-1:0]    active,
  output logic [NCH-1:0]    frame_end,
  output logic [NCH-1:0]    stoff,
  output logic [NCH-1:0]    sint
);
  logic [NCH-1:0] snd_q, rise, elig, at_end, hit, fe_n;
  logic [AW-1:0]  cur [NCH];
  logic [AW-1:0]  en [NCH];
  logic [CW-1:0]  last, gch;
  logic           gnt;
  int             idx;

  assign rise = snd_on & ~snd_q;
  assign elig = active & sreq & snd_on;

  // round-robin search starting at the channel after the last grant
  always_comb begin
    gnt = 1'b0;
    gch = '0;
    idx = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(last) + k) % NCH;
      if (slot && !gnt && elig[idx]) begin
        gnt = 1'b1;
        gch = CW'(idx);
      end
    end
  end

  // per-channel grant decode and end-of-frame compare
  always_comb begin
    at_end = '0;
    hit = '0;
    fe_n = '0;
    for (int i = 0; i < NCH; i++) begin
      at_end[i] = cur[i] == en[i];
      hit[i] = gnt && gch == CW'(i);
      fe_n[i] = hit[i] && at_end[i];
    end
  end

`ifdef SND_DMA_SHADOW_EN
  // end address captured at activation and at each repeat wrap, so mid-frame writes wait for the next frame
  always_ff @(posedge clk or posedge por)
    if (por) for (int i = 0; i < NCH; i++) en[i] <= '0;
    else for (int i = 0; i < NCH; i++) if (rise[i] || (fe_n[i] && rep[i])) en[i] <= end_addr[i*AW +: AW];
`else
  // end address follows the port every cycle
  always_comb for (int i = 0; i < NCH; i++) en[i] = end_addr[i*AW +: AW];
`endif

  // fetch register, channel activation, frame counters and sticky interrupts
  always_ff @(posedge clk or posedge por)
    if (por) begin
      snd_q <= '0;
      active <= '0;
      sint <= '0;
      frame_end <= '0;
      stoff <= '0;
      dma_load <= 1'b0;
      dma_ch <= '0;
      dma_addr <= '0;
      last <= '0;
      for (int i = 0; i < NCH; i++) cur[i] <= '0;
    end else begin
      snd_q <= snd_on;
      dma_load <= gnt;
      frame_end <= fe_n;
      stoff <= fe_n & ~rep;
      sint <= fe_n | (sint & ~int_ack);
      if (gnt) begin
        dma_ch <= gch;
        dma_addr <= cur[gch];
        last <= gch;
      end
      for (int i = 0; i < NCH; i++)
        if (!snd_on[i]) active[i] <= 1'b0;
        else if (rise[i]) begin
          active[i] <= 1'b1;
          cur[i] <= start_addr[i*AW +: AW];
        end else if (hit[i]) begin
          if (!at_end[i]) cur[i] <= cur[i] + 1'b1;
          else if (rep[i]) cur[i] <= start_addr[i*AW +: AW];
          else active[i] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_snd_dma_seq.sv
// tb_snd_dma_seq: scoreboard bench for snd_dma_seq with a behavioural channel model and directed frame scenarios
module tb_snd_dma_seq;
  localparam int NCH = 2;
  localparam int AW = 21;
  localparam int CW = 1;
  localparam int MASK = (1 << AW) - 1;

  logic              clk = 1'b0;
  logic              por = 1'b1;
  logic              slot = 1'b0;
  logic [NCH-1:0]    snd_on = '0, rep = '0, sreq = '0, int_ack = '0;
  logic [NCH*AW-1:0] start_addr = '0, end_addr = '0;
  logic              dma_load;
  logic [CW-1:0]     dma_ch;
  logic [AW-1:0]     dma_addr;
  logic [NCH-1:0]    active, frame_end, stoff, sint;

  snd_dma_seq #(.NCH(NCH), .AW(AW)) dut (
    .clk(clk), .por(por), .slot(slot), .snd_on(snd_on), .rep(rep),
    .start_addr(start_addr), .end_addr(end_addr), .sreq(sreq), .int_ack(int_ack),
    .dma_load(dma_load), .dma_ch(dma_ch), .dma_addr(dma_addr), .active(active),
    .frame_end(frame_end), .stoff(stoff), .sint(sint)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int addr;
    logic [NCH-1:0] fe;
    logic [NCH-1:0] so;
  } fetch_t;

  fetch_t sq[$];
  int log_addr[$], log_ch[$], log_fe[$], log_so[$];
  int total = 0, bad = 0;

  int m_cur[NCH], m_end[NCH], m_last;
  logic [NCH-1:0] m_act, m_sint, m_son;

  function automatic int s_of(int i);
    return int'(start_addr[i*AW +: AW]);
  endfunction

  function automatic int e_of(int i);
    return int'(end_addr[i*AW +: AW]);
  endfunction

  function automatic int endv(int i);
`ifdef SND_DMA_SHADOW_EN
    return m_end[i];
`else
    return e_of(i);
`endif
  endfunction

  // reference model: one step of the channel rules per clock, expected fetches go to the scoreboard
  always @(posedge clk or posedge por) begin : mdl
    int g;
    bit e;
    fetch_t f;
    if (por) begin
      m_act = '0; m_sint = '0; m_son = '0; m_last = 0;
      for (int i = 0; i < NCH; i++) begin m_cur[i] = 0; m_end[i] = 0; end
      sq.delete();
    end else begin
      g = -1;
      e = 0;
      if (slot)
        for (int k = 1; k <= NCH; k++)
          if (g < 0 && m_act[(m_last + k) % NCH] && sreq[(m_last + k) % NCH] && snd_on[(m_last + k) % NCH])
            g = (m_last + k) % NCH;
      if (g >= 0) begin
        e = m_cur[g] == endv(g);
        f.ch = g; f.addr = m_cur[g]; f.fe = '0; f.so = '0;
        if (e) begin
          f.fe[g] = 1'b1;
          f.so[g] = !rep[g];
        end
        sq.push_back(f);
        m_last = g;
      end
      for (int i = 0; i < NCH; i++) begin
        if (g == i && e) m_sint[i] = 1'b1;
        else if (int_ack[i]) m_sint[i] = 1'b0;
        if (!snd_on[i]) m_act[i] = 1'b0;
        else if (!m_son[i]) begin
          m_act[i] = 1'b1; m_cur[i] = s_of(i); m_end[i] = e_of(i);
        end else if (g == i) begin
          if (!e) m_cur[i] = (m_cur[i] + 1) & MASK;
          else if (rep[i]) begin m_cur[i] = s_of(i); m_end[i] = e_of(i); end
          else m_act[i] = 1'b0;
        end
        m_son[i] = snd_on[i];
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a fetch, checks levels every cycle
  always @(negedge clk) begin : mon
    fetch_t f;
    if (por) begin
      total++;
      if (dma_load || dma_ch != 0 || dma_addr != 0 || active != 0 || frame_end != 0 || stoff != 0 || sint != 0) begin
        bad++;
        $display("FAIL reset_outputs load=%b ch=%0d addr=%h act=%b fe=%b so=%b sint=%b required all zero",
                 dma_load, dma_ch, dma_addr, active, frame_end, stoff, sint);
      end
    end else begin
      total++;
      if (dma_load) begin
        log_addr.push_back(int'(dma_addr)); log_ch.push_back(int'(dma_ch));
        log_fe.push_back(int'(frame_end)); log_so.push_back(int'(stoff));
        if (sq.size() == 0) begin
          bad++;
          $display("FAIL spurious_load ch=%0d addr=%h required no fetch", dma_ch, dma_addr);
        end else begin
          f = sq.pop_front();
          if (int'(dma_ch) != f.ch || int'(dma_addr) != f.addr || frame_end != f.fe || stoff != f.so) begin
            bad++;
            $display("FAIL fetch got ch=%0d addr=%h fe=%b so=%b required ch=%0d addr=%h fe=%b so=%b",
                     dma_ch, dma_addr, frame_end, stoff, f.ch, f.addr, f.fe, f.so);
          end
        end
      end else if (sq.size() != 0 || frame_end != 0 || stoff != 0) begin
        bad++;
        $display("FAIL missing_load pending=%0d fe=%b so=%b required fetch or quiet pulses", sq.size(), frame_end, stoff);
        sq.delete();
      end
      total++;
      if (active != m_act || sint != m_sint) begin
        bad++;
        $display("FAIL levels act=%b sint=%b required act=%b sint=%b", active, sint, m_act, m_sint);
      end
    end
  end

  task automatic chk(string nm, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", nm, got, exp);
    end
  endtask

  task automatic cyc(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_ch(int i, int s, int e);
    start_addr[i*AW +: AW] = AW'(s & MASK);
    end_addr[i*AW +: AW] = AW'(e & MASK);
  endtask

  task automatic clr_log();
    log_addr.delete(); log_ch.delete(); log_fe.delete(); log_so.delete();
  endtask

  task automatic reset_dut();
    snd_on = '0; slot = 1'b0; int_ack = '0;
    por = 1'b1;
    cyc(2);
    por = 1'b0;
    clr_log();
  endtask

  int exp_a[], exp_c[];

  initial begin
    cyc(1);
    // single shot frame
    reset_dut();
    set_ch(0, 'h100, 'h102); set_ch(1, 0, 0); rep = 2'b00; sreq = 2'b11;
    slot = 1'b1; snd_on = 2'b01;
    cyc(8);
    chk("ss_count", log_addr.size(), 3);
    exp_a = '{'h100, 'h101, 'h102};
    for (int k = 0; k < 3 && k < log_addr.size(); k++) chk("ss_addr", log_addr[k], exp_a[k]);
    if (log_fe.size() == 3) begin
      chk("ss_fe_mid", log_fe[1], 0);
      chk("ss_fe_last", log_fe[2], 1);
      chk("ss_stoff_last", log_so[2], 1);
    end
    chk("ss_sint", int'(sint[0]), 1);
    chk("ss_active", int'(active[0]), 0);

    // two channels alternating, both repeating
    reset_dut();
    set_ch(0, 'h10, 'h11); set_ch(1, 'h20, 'h21); rep = 2'b11; sreq = 2'b11;
    slot = 1'b1; snd_on = 2'b11;
    cyc(8);
    slot = 1'b0;
    cyc(2);
    exp_a = '{'h20, 'h10, 'h21, 'h11, 'h20, 'h10};
    exp_c = '{1, 0, 1, 0, 1, 0};
    chk("rr_count_ge6", int'(log_addr.size() >= 6), 1);
    for (int k = 0; k < 6 && k < log_addr.size(); k++) begin
      chk("rr_addr", log_addr[k], exp_a[k]);
      chk("rr_ch", log_ch[k], exp_c[k]);
    end
    if (log_fe.size() >= 4) begin
      chk("rr_fe_ch1", log_fe[2], 2);
      chk("rr_fe_ch0", log_fe[3], 1);
    end

    // start above end: counter wraps through zero
    reset_dut();
    set_ch(0, 'h1FFFFF, 'h1); set_ch(1, 0, 0); rep = 2'b01; sreq = 2'b01;
    slot = 1'b1; snd_on = 2'b01;
    cyc(6);
    slot = 1'b0;
    cyc(2);
    exp_a = '{'h1FFFFF, 'h0, 'h1, 'h1FFFFF};
    for (int k = 0; k < 4; k++) chk("wrap_addr", k < log_addr.size() ? log_addr[k] : -1, exp_a[k]);

    // acknowledge coincident with the frame-end grant: set wins
    reset_dut();
    set_ch(0, 'h40, 'h41); rep = 2'b01; sreq = 2'b01; snd_on = 2'b01;
    cyc(1);
    slot = 1'b1;
    cyc(1);
    int_ack = 2'b01;
    cyc(1);
    slot = 1'b0; int_ack = 2'b00;
    cyc(1);
    chk("ack_coincident_sint", int'(sint[0]), 1);
    int_ack = 2'b01;
    cyc(1);
    int_ack = 2'b00;
    chk("ack_alone_sint", int'(sint[0]), 0);

    // reset mid-frame with snd_on held high
    reset_dut();
    set_ch(0, 'h200, 'h20F); rep = 2'b01; sreq = 2'b01; slot = 1'b1; snd_on = 2'b01;
    cyc(5);
    por = 1'b1;
    cyc(1);
    chk("por_active", int'(active), 0);
    chk("por_load", int'(dma_load), 0);
    cyc(2);
    por = 1'b0;
    clr_log();
    cyc(4);
    slot = 1'b0;
    cyc(1);
    chk("por_first_addr", log_addr.size() > 0 ? log_addr[0] : -1, 'h200);
    chk("por_second_addr", log_addr.size() > 1 ? log_addr[1] : -1, 'h201);

    // end address lowered mid-frame
    reset_dut();
    set_ch(0, 'h100, 'h103); rep = 2'b01; sreq = 2'b01; snd_on = 2'b01;
    cyc(1);
    slot = 1'b1;
    cyc(3);
    set_ch(0, 'h100, 'h101);
    cyc(4);
    slot = 1'b0;
    cyc(1);
`ifdef SND_DMA_SHADOW_EN
    exp_a = '{'h100, 'h101, 'h102, 'h103, 'h100, 'h101, 'h100};
`else
    exp_a = '{'h100, 'h101, 'h102, 'h103, 'h104, 'h105, 'h106};
`endif
    for (int k = 0; k < 7; k++) chk("endchg_addr", k < log_addr.size() ? log_addr[k] : -1, exp_a[k]);

    // randomized traffic checked by the scoreboard
    reset_dut();
    rep = 2'b11;
    for (int i = 0; i < NCH; i++) set_ch(i, 'h300 + 4 * i, 'h303 + 4 * i);
    for (int n = 0; n < 3000; n++) begin
      slot = $urandom_range(0, 3) != 0;
      sreq = NCH'($urandom);
      int_ack = $urandom_range(0, 7) == 0 ? NCH'($urandom) : '0;
      if ($urandom_range(0, 40) == 0) snd_on = NCH'($urandom | $urandom);
      if ($urandom_range(0, 20) == 0) rep = NCH'($urandom);
      if ($urandom_range(0, 30) == 0) begin
        int b;
        b = $urandom_range(0, 1) ? 'h300 : 'h1FFFFC;
        set_ch($urandom_range(0, NCH - 1), b + $urandom_range(0, 7), b + $urandom_range(0, 7));
      end
      if ($urandom_range(0, 600) == 0) begin
        por = 1'b1;
        cyc(1);
        por = 1'b0;
      end
      cyc(1);
    end
    slot = 1'b0;
    cyc(3);
    chk("queue_drained", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/snd_dma_seq.md
# snd_dma_seq

Parametrised multi-channel sound DMA sequencer for the MCU control path. It shares the sound DMA time slot round-robin among `NCH` channels and keeps a per-channel frame address counter. It detects the end-of-frame address and either reloads the frame (repeat mode) or stops the channel. It raises a per-channel frame interrupt. It sits between the slot generator (video/refresh/sound cycle decode) and the DMA address multiplexer, replacing the single-channel frame logic.

## Interface
- `NCH`, 2, number of sound channels (1..8).
- `AW`, 21, word-address width (bits [AW:1] of the byte address).
- `CW`, derived as max(1, clog2(NCH)); width of the channel index. Not user-set.
- `clk`  in  1  system clock. All state changes on the rising edge.
- `por`  in  1  reset, asynchronous, active-high.
- `slot`  in  1  one-cycle strobe: a sound DMA bus cycle is available this clock.
- `snd_on`  in  NCH  per-channel enable, level.
- `rep`  in  NCH  per-channel repeat mode: 1 = loop frame, 0 = single shot.
- `start_addr`  in  NCH*AW  per-channel frame start word address; channel i occupies bits [i*AW +: AW].
- `end_addr`  in  NCH*AW  per-channel frame end word address, inclusive.
- `sreq`  in  NCH  per-channel FIFO refill request, level.
- `int_ack`  in  NCH  per-channel interrupt clear, one-cycle pulse.
- `dma_load`  out  1  one-cycle pulse: a DMA word fetch is issued.
- `dma_ch`  out  CW  channel granted, valid while `dma_load` is high.
- `dma_addr`  out  AW  word address fetched, valid while `dma_load` is high.
- `active`  out  NCH  channel running.
- `frame_end`  out  NCH  one-cycle pulse on the last word of a frame.
- `stoff`  out  NCH  one-cycle pulse when a single-shot channel stops at frame end.
- `sint`  out  NCH  frame interrupt, level, sticky until acknowledged.

## Operation
- Per channel: `snd_on` is registered and edge-detected.
  - A rising edge sets `active[i]` and loads `cur[i] <= start[i]` on the following edge.
  - `snd_on` low clears `active[i]` on the next edge. Clearing through `snd_on` does not pulse `stoff`.
- Eligibility: channel i is eligible when `active[i] & sreq[i] & snd_on[i]`.
- Arbiter: round-robin with a `last` pointer (reset 0).
  - On `slot`, search eligible channels starting at `last+1` modulo NCH. The first hit is granted and `last` is set to it.
  - No eligible channel means no grant; `last` is unchanged.
- Grant actions:
  - Register `dma_ch` = i, `dma_addr` = `cur[i]`, `dma_load` = 1.
  - If `cur[i] == end[i]`: pulse `frame_end[i]` and set `sint[i]`.
    - `rep[i]` = 1: `cur[i] <= start[i]`.
    - `rep[i]` = 0: clear `active[i]` and pulse `stoff[i]`.
  - Otherwise: `cur[i] <= cur[i] + 1`, modulo 2^AW, so 2^AW−1 wraps to 0.
- The end compare is an exact AW-bit equality. If `start == end`, each frame is a single word.
- If `start > end`, the counter runs through the wrap to 0 until it reaches `end`; this is defined behaviour, not an error.
- `sint[i]`: set on `frame_end[i]` and cleared by `int_ack[i]`. If set and clear arrive in the same cycle, set wins.

## Timing
- Reset (`por` high, any time, including mid-frame):
  - `active`, `sint`, `frame_end`, `stoff`, `dma_load` are 0.
  - `dma_ch`, `dma_addr`, `last`, `cur[*]` are 0.
  - The registered `snd_on` is 0, so a high `snd_on` at reset release restarts the channel.
- `snd_on` rising at edge n: `active` is high after edge n+1. A `slot` in cycle n+1 can already grant.
- `slot` high in cycle n: `dma_load`, `dma_ch`, `dma_addr`, `frame_end` and `stoff` are high/valid during cycle n+1 only. `sint` and `active` update at the same edge.
- At most one grant per `slot`. Back-to-back `slot` strobes are allowed: one grant per cycle, with counters updated each cycle.
- `snd_on` falling in the same cycle as `slot`: that channel is not granted.
- A `rep` change is sampled at the end-of-frame grant only.

## Configuration
- `SND_DMA_SHADOW_EN` defined:
  - `start[i]` and `end[i]` are shadow registers, loaded from the ports on activation and at every repeat wrap.
  - Port changes mid-frame take effect from the next frame.
- Not defined: `start[i]` and `end[i]` are the live port values every cycle, and mid-frame writes act immediately.

## Test plan
- NCH=2, AW=21; ch0 start 0x100, end 0x102, rep 0; `sreq` high, `slot` every cycle.
  - Required: `dma_addr` 0x100, 0x101, 0x102.
  - `frame_end[0]`, `stoff[0]` and `sint[0]` assert with the 0x102 fetch.
  - `active[0]` drops; no further `dma_load`.
- ch0 at 0x10–0x11 and ch1 at 0x20–0x21, both rep 1, both requesting.
  - Required: grants alternate ch1, ch0, ch1, ...
  - Addresses 0x20, 0x10, 0x21, 0x11, 0x20, 0x10.
  - `frame_end` pulses on each 0x21 and 0x11 fetch.
- start 0x1FFFFF, end 0x000001, rep 1.
  - Required: 0x1FFFFF, 0x000000, 0x000001, then 0x1FFFFF.
- `por` pulsed mid-frame with `snd_on` held high.
  - Required: all outputs 0 during reset; the first fetch after release is at `start_addr`.
- `int_ack[0]` coincident with `frame_end[0]`.
  - Required: `sint[0]` stays 1; a later lone `int_ack[0]` clears it.
- With `SND_DMA_SHADOW_EN`, change `end_addr` mid-frame from 0x103 to 0x101 while at 0x102.
  - Required: the current frame still ends at 0x103; the next frame ends at 0x101.
- Without `SND_DMA_SHADOW_EN`, the same change mid-frame.
  - Required: the counter passes 0x101 without stopping and wraps.
